ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the FPGA to the keyboard. It is the opposite direction of the PS/2 receive path in Keyboard_Decoder. It drives the open-drain PS/2 clock and data pads through pull-low enables and follows the standard host request-to-send sequence. While it is active it raises `busy` so the receive path can ignore bus activity.

---
 rtl/ps2_pkg.sv | 46 ++++
 rtl/ps2_sync_edge.sv | 34 +++
 rtl/ps2_host_tx.sv | 199 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit states, frame layout and keyboard command bytes.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_DATA_BITS  = 8;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_t;

  typedef struct packed {
    logic                     parity;
    logic [PS2_DATA_BITS-1:0] data;
  } ps2_frame_t;

  // Latched command byte with its odd-parity bit.
  function automatic ps2_frame_t ps2_make_frame(input logic [PS2_DATA_BITS-1:0] data);
    ps2_frame_t frame;
    frame.parity = ~^data;
    frame.data   = data;
    return frame;
  endfunction

  // Bit put on the line after falling edge idx: data LSB first, parity, then stop (always 1).
  function automatic logic ps2_frame_bit(input ps2_frame_t frame, input logic [3:0] idx);
    logic bit_v;
    if (idx < 4'(PS2_DATA_BITS)) begin
      bit_v = frame.data[idx[2:0]];
    end else if (idx == 4'(PS2_DATA_BITS)) begin
      bit_v = frame.parity;
    end else begin
      bit_v = 1'b1;
    end
    return bit_v;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for PS/2 pad inputs plus a falling-edge strobe per bit.
module ps2_sync_edge
  import ps2_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] fall_c_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  // Reset to the idle-high bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '1;
      sync_q <= '1;
      prev_q <= '1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o   = sync_q;
  assign fall_c_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 11-bit frame, ACK check and timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clock_i,
  input  logic       ps2_data_i,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = 4;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PS2_FRAME_BITS - 2);

  logic [1:0] pad_sync;
  logic [1:0] pad_fall;
  logic       clk_sync;
  logic       data_sync;
  logic       clk_fall;
  logic       unused_data_fall;

  ps2_sync_edge #(
    .WIDTH (2)
  ) u_sync (
    .clk_i    (clock),
    .rst_n_i  (reset_n),
    .async_i  ({ps2_data_i, ps2_clock_i}),
    .sync_o   (pad_sync),
    .fall_c_o (pad_fall)
  );

  assign clk_sync         = pad_sync[0];
  assign data_sync        = pad_sync[1];
  assign clk_fall         = pad_fall[0];
  assign unused_data_fall = pad_fall[1];

  ps2_tx_state_t    state_q, state_d;
  ps2_frame_t       frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             ack_q, ack_d;
  logic             clock_oe_q, clock_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             tx_ready_q, tx_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             in_frame_c;
  logic             timeout_c;

  // cnt_q times the inhibit phase, then restarts at START as the transaction timeout.
  assign in_frame_c = (state_q == ST_SEND) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
  assign timeout_c  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    ack_d      = ack_q;
    clock_oe_d = clock_oe_q;
    data_oe_d  = data_oe_q;
    tx_ready_d = tx_ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          frame_d    = ps2_make_frame(tx_data);
          state_d    = ST_INHIBIT;
          cnt_d      = '0;
          bit_d      = '0;
          clock_oe_d = 1'b1;
          data_oe_d  = 1'b0;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          state_d   = ST_START;
          data_oe_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_START: begin
        state_d    = ST_SEND;
        clock_oe_d = 1'b0;
        cnt_d      = cnt_q + CNT_W'(1);
      end
      ST_SEND: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clk_fall) begin
          data_oe_d = ~ps2_frame_bit(frame_q, bit_q);
          if (bit_q == LAST_BIT) begin
            state_d = ST_ACK;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clk_fall) begin
          ack_d   = ~data_sync;
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clk_sync && data_sync) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          clock_oe_d = 1'b0;
          data_oe_d  = 1'b0;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
          done_d     = ack_q;
          error_d    = ~ack_q;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        clock_oe_d = 1'b0;
        data_oe_d  = 1'b0;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase

    // Timeout wins over any normal completion in the same cycle.
    if (in_frame_c && timeout_c) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      bit_d      = '0;
      clock_oe_d = 1'b0;
      data_oe_d  = 1'b0;
      tx_ready_d = 1'b1;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      error_d    = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      ack_q      <= 1'b0;
      clock_oe_q <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      ack_q      <= ack_d;
      clock_oe_q <= clock_oe_d;
      data_oe_q  <= data_oe_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign ps2_clock_oe = clock_oe_q;
  assign ps2_data_oe  = data_oe_q;
  assign tx_ready     = tx_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: keyboard-side BFM, result/frame scoreboards and directed timing checks.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned TB_INHIBIT  = 100;
  localparam int unsigned TB_TIMEOUT  = 50000;
  localparam int unsigned FRAME_BOUND = 12000;
  localparam logic [1:0]  RES_DONE    = 2'b10;
  localparam logic [1:0]  RES_ERROR   = 2'b01;
  localparam int          BFM_ACK     = 0;
  localparam int          BFM_NACK    = 1;
  localparam int          BFM_SILENT  = 2;

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ps2_clock_oe, ps2_data_oe, tx_ready, busy, done, error;

  logic bfm_clk      = 1'b1;
  logic bfm_data_low = 1'b0;
  logic ps2_clock_line, ps2_data_line;
  assign ps2_clock_line = bfm_clk & ~ps2_clock_oe;
  assign ps2_data_line  = ~bfm_data_low & ~ps2_data_oe;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int bfm_half = 400;
  int bfm_mode = BFM_ACK;
  int bfm_bit  = -1;
  bit bfm_abort  = 1'b0;
  bit bfm_active = 1'b0;

  logic [9:0] exp_frames[$];
  logic [1:0] exp_results[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES (TB_INHIBIT),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ps2_clock_i  (ps2_clock_line),
    .ps2_data_i   (ps2_data_line),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected line bits as the device samples them: data[7:0], parity, stop.
  function automatic logic [9:0] frame_of(input logic [7:0] b, input logic p);
    return {1'b1, p, b};
  endfunction

  // Device side: clock out 10 bits, sampling on each rising edge, then the ACK slot.
  task automatic run_frame();
    logic [9:0] got;
    bit aborted;
    got = '0;
    aborted = 1'b0;
    bfm_active = 1'b1;
    repeat (20) @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      bfm_bit = i;
      bfm_clk = 1'b0;
      repeat (bfm_half) @(negedge clock);
      if (bfm_abort) begin aborted = 1'b1; break; end
      got[i] = ps2_data_line;
      bfm_clk = 1'b1;
      repeat (bfm_half) @(negedge clock);
      if (bfm_abort) begin aborted = 1'b1; break; end
    end
    if (!aborted) begin
      bfm_bit = 10;
      bfm_data_low = (bfm_mode == BFM_ACK);
      repeat (20) @(negedge clock);
      bfm_clk = 1'b0;
      repeat (bfm_half) @(negedge clock);
      bfm_clk = 1'b1;
      repeat (20) @(negedge clock);
      bfm_data_low = 1'b0;
      if (exp_frames.size() == 0) check("unexpected_frame", 32'(exp_frames.size()), 32'd1);
      else check("frame_bits", 32'(got), 32'(exp_frames.pop_front()));
    end
    bfm_clk = 1'b1;
    bfm_data_low = 1'b0;
    bfm_bit = -1;
    bfm_active = 1'b0;
  endtask

  initial begin : bfm
    forever begin
      @(negedge clock);
      if (reset_n && ps2_data_oe && !ps2_clock_oe && bfm_mode != BFM_SILENT && !bfm_abort)
        run_frame();
    end
  end

  // Scoreboard monitor: every done/error pulse is matched against the next expected outcome.
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (reset_n && (done || error)) begin
        check("done_error_exclusive", 32'(done & error), 32'd0);
        if (exp_results.size() == 0) check("unexpected_result", 32'({done, error}), 32'd0);
        else check("result", 32'({done, error}), 32'(exp_results.pop_front()));
      end
    end
  end

  initial begin : watchdog
    repeat (95000) @(posedge clock);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [7:0] b, output int n_acc);
    @(negedge clock);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clock);
    #1;
    n_acc = cyc;
    tx_valid = 1'b0;
    check("accept_state", 32'({ps2_clock_oe, busy, tx_ready}), 32'(3'b110));
  endtask

  task automatic check_inhibit(input int n_acc, output int s_cyc);
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while (!ps2_data_oe && n < int'(TB_INHIBIT) + 10);
    s_cyc = cyc;
    check("start_data_oe", 32'(ps2_data_oe), 32'd1);
    check("inhibit_len", 32'(cyc - n_acc), 32'(TB_INHIBIT));
    check("start_clock_oe", 32'(ps2_clock_oe), 32'd1);
    @(negedge clock);
    check("send_clock_released", 32'(ps2_clock_oe), 32'd0);
  endtask

  task automatic wait_result(input int bound, input string name);
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while (!(done || error) && n < bound);
    if (!(done || error)) check({name, "_no_pulse"}, 32'({done, error}), 32'd1);
  endtask

  initial begin : stim
    int n_acc, s_cyc, n;
    repeat (3) @(negedge clock);
    check("reset_outputs", 32'({ps2_clock_oe, ps2_data_oe, tx_ready, busy, done, error}),
          32'(6'b001000));
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_ready", 32'({tx_ready, busy}), 32'(2'b10));

    // 0xED, slow device clock, ACK
    bfm_half = 400; bfm_mode = BFM_ACK;
    exp_frames.push_back(frame_of(8'hED, 1'b1));
    exp_results.push_back(RES_DONE);
    send(PS2_CMD_SET_LED, n_acc);
    check_inhibit(n_acc, s_cyc);
    wait_result(FRAME_BOUND, "t1");
    check("t1_ready_after_done", 32'({tx_ready, busy, done}), 32'(3'b101));

    // 0x01, parity bit 0
    bfm_half = 100;
    exp_frames.push_back(frame_of(8'h01, 1'b0));
    exp_results.push_back(RES_DONE);
    send(8'h01, n_acc);
    wait_result(FRAME_BOUND, "t2");
    check("t2_lines_released", 32'({ps2_clock_oe, ps2_data_oe}), 32'd0);

    // 0xF4, device NACKs
    bfm_mode = BFM_NACK;
    exp_frames.push_back(frame_of(8'hF4, 1'b0));
    exp_results.push_back(RES_ERROR);
    send(PS2_CMD_ENABLE, n_acc);
    wait_result(FRAME_BOUND, "t3");
    check("t3_error_lines_released", 32'({ps2_clock_oe, ps2_data_oe, done, error}), 32'(4'b0001));

    // 0xFF, device never clocks: timeout measured from START
    bfm_mode = BFM_SILENT;
    exp_results.push_back(RES_ERROR);
    send(PS2_CMD_RESET, n_acc);
    check_inhibit(n_acc, s_cyc);
    wait_result(int'(TB_TIMEOUT) + 200, "t4");
    check("t4_timeout_len", 32'(cyc - s_cyc), 32'(TB_TIMEOUT));
    check("t4_lines_released", 32'({ps2_clock_oe, ps2_data_oe, tx_ready}), 32'(3'b001));

    // Reset while data bit 4 (a zero in 0xED) is on the line
    bfm_mode = BFM_ACK;
    send(PS2_CMD_SET_LED, n_acc);
    n = 0;
    do begin @(negedge clock); n++; end while (bfm_bit != 4 && n < int'(FRAME_BOUND));
    repeat (10) @(negedge clock);
    check("t5_bit4_pulled_low", 32'(ps2_data_oe), 32'd1);
    bfm_abort = 1'b1;
    reset_n = 1'b0;
    #1;
    check("t5_reset_release", 32'({ps2_clock_oe, ps2_data_oe, tx_ready, busy}), 32'(4'b0010));
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (bfm_active && n < int'(FRAME_BOUND));
    bfm_abort = 1'b0;
    check("t5_ready_after_reset", 32'({tx_ready, busy}), 32'(2'b10));
    exp_frames.push_back(frame_of(8'hF4, 1'b0));
    exp_results.push_back(RES_DONE);
    send(PS2_CMD_ENABLE, n_acc);
    wait_result(FRAME_BOUND, "t5b");

    // tx_valid held: 0xED then 0x02 back to back
    exp_frames.push_back(frame_of(8'hED, 1'b1));
    exp_frames.push_back(frame_of(8'h02, 1'b0));
    exp_results.push_back(RES_DONE);
    exp_results.push_back(RES_DONE);
    @(negedge clock);
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    @(posedge clock);
    #1;
    n_acc   = cyc;
    tx_data = 8'h02;
    check_inhibit(n_acc, s_cyc);
    wait_result(FRAME_BOUND, "t6_first");
    check("t6_ready_in_done_cycle", 32'({tx_ready, done}), 32'(2'b11));
    @(posedge clock);
    #1;
    n_acc = cyc;
    check("t6_second_accept", 32'({ps2_clock_oe, busy, tx_ready}), 32'(3'b110));
    tx_valid = 1'b0;
    check_inhibit(n_acc, s_cyc);
    wait_result(FRAME_BOUND, "t6_second");

    repeat (20) @(negedge clock);
    check("scoreboard_drained", 32'(exp_results.size() + exp_frames.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
